// File: rtl/rtc_stopwatch.sv
// rtc_stopwatch: BCD count-up stopwatch (HH:MM:SS plus binary sub-second)
// with sticky overflow, a wrap interrupt and an optional lap register.
// Optional feature macro: STOPWATCH_LAP_EN (lap storage and o_lap output).
// The next-time value is prepared by a two-stage pipeline that follows
// bcd_time. A tick only loads that prepared value, which is safe because
// ticks are always at least four clocks apart.
module rtc_stopwatch #(
  parameter int LGSUBCK = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sub_ck,
  input  logic        i_wr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic [31:0] o_lap,
  output logic        o_interrupt
);

  logic [23:0]        bcd_time;
  logic [LGSUBCK-1:0] tm_sub;
  logic               running;
  logic               overflow;
  logic               tick;

  assign tick   = i_sub_ck && running && (&tm_sub);
  assign o_data = {6'h0, overflow, running, bcd_time};

  // Advance one BCD digit when carried into; roll to zero at its maximum.
  function automatic logic [3:0] step_digit(input logic [3:0] d,
                                            input logic       carry_in,
                                            input logic       at_max);
    if (!carry_in)
      return d;
    else if (at_max)
      return 4'd0;
    else
      return d + 4'd1;
  endfunction

  // Stage p0: snapshot of the time and which digits sit at their maximum.
  logic [23:0] time_p0;
  logic [5:0]  at_max_p0;

  // Capture time and per-digit at-max flags.
  always_ff @(posedge i_clk) begin
    time_p0   <= bcd_time;
    at_max_p0 <= {bcd_time[23:20] == 4'd9,
                  bcd_time[19:16] == 4'd9,
                  bcd_time[14:12] == 3'd5,
                  bcd_time[11:8]  == 4'd9,
                  bcd_time[6:4]   == 3'd5,
                  bcd_time[3:0]   == 4'd9};
  end

  // Stage p1: AND-chained carries produce the incremented time.
  logic [5:0]  carry_c;
  logic [23:0] next_c;
  logic [3:0]  sec_tens_c;
  logic [3:0]  min_tens_c;
  logic [23:0] next_p1;
  logic        wrap_p1;

  assign carry_c[0] = 1'b1;
  assign carry_c[1] = carry_c[0] & at_max_p0[0];
  assign carry_c[2] = carry_c[1] & at_max_p0[1];
  assign carry_c[3] = carry_c[2] & at_max_p0[2];
  assign carry_c[4] = carry_c[3] & at_max_p0[3];
  assign carry_c[5] = carry_c[4] & at_max_p0[4];

  // Assemble the next time; bits 7 and 15 always stay zero.
  always_comb begin
    next_c         = '0;
    sec_tens_c     = step_digit({1'b0, time_p0[6:4]}, carry_c[1], at_max_p0[1]);
    min_tens_c     = step_digit({1'b0, time_p0[14:12]}, carry_c[3], at_max_p0[3]);
    next_c[3:0]    = step_digit(time_p0[3:0], carry_c[0], at_max_p0[0]);
    next_c[6:4]    = sec_tens_c[2:0];
    next_c[11:8]   = step_digit(time_p0[11:8], carry_c[2], at_max_p0[2]);
    next_c[14:12]  = min_tens_c[2:0];
    next_c[19:16]  = step_digit(time_p0[19:16], carry_c[4], at_max_p0[4]);
    next_c[23:20]  = step_digit(time_p0[23:20], carry_c[5], at_max_p0[5]);
  end

  // Register the prepared next time and its wrap flag.
  always_ff @(posedge i_clk) begin
    next_p1 <= next_c;
    wrap_p1 <= &at_max_p0;
  end

  // Control and time state: later assignments take priority, so the order
  // is clear-overflow, then tick (overflow set wins), then full clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      running     <= 1'b0;
      overflow    <= 1'b0;
      tm_sub      <= '0;
      bcd_time    <= '0;
      o_interrupt <= 1'b0;
    end else begin
      o_interrupt <= 1'b0;
      if (i_sub_ck && running)
        tm_sub <= tm_sub + 1'b1;
      if (i_wr && i_data[3])
        overflow <= 1'b0;
      if (tick) begin
        bcd_time <= next_p1;
        if (wrap_p1) begin
          overflow    <= 1'b1;
          o_interrupt <= 1'b1;
        end
      end
      if (i_wr) begin
        running <= i_data[0];
        if (i_data[1]) begin
          bcd_time    <= '0;
          tm_sub      <= '0;
          overflow    <= 1'b0;
          o_interrupt <= 1'b0;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [7:0]  frac;
  logic [31:0] lap_q;
  logic        unused_data;

  generate
    if (LGSUBCK >= 8) begin : g_frac_wide
      assign frac = tm_sub[LGSUBCK-1 -: 8];
    end else begin : g_frac_narrow
      assign frac = {tm_sub, {(8 - LGSUBCK){1'b0}}};
    end
  endgenerate

  assign unused_data = &{1'b0, i_data[31:4]};
  assign o_lap       = lap_q;

  // Lap captures the pre-update time and sub-second of the write cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      lap_q <= '0;
    else if (i_wr && i_data[2])
      lap_q <= {frac, bcd_time};
  end
`else
  logic unused_data;

  assign unused_data = &{1'b0, i_data[31:4], i_data[2]};
  assign o_lap       = 32'h0;
`endif

endmodule

// File: tb/tb_rtc_stopwatch.sv
// tb_rtc_stopwatch: directed self-checking bench for rtc_stopwatch with
// LGSUBCK=2 and i_sub_ck driven every second clock.
module tb_rtc_stopwatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sub_ck = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] o_data;
  logic [31:0] o_lap;
  logic        o_int;

  int          errors = 0;
  int          checks = 0;
  int          irq_count = 0;
  logic [23:0] force_val = 24'h0;

`ifdef STOPWATCH_LAP_EN
  localparam logic [31:0] LAP_EXP = 32'h80000005;
`else
  localparam logic [31:0] LAP_EXP = 32'h00000000;
`endif

  always #5 clk = ~clk;

  rtc_stopwatch #(.LGSUBCK(2)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_sub_ck    (sub_ck),
    .i_wr        (wr),
    .i_data      (wdata),
    .o_data      (o_data),
    .o_lap       (o_lap),
    .o_interrupt (o_int)
  );

  // Count every cycle the interrupt is seen high.
  always @(negedge clk) begin
    if (o_int === 1'b1)
      irq_count <= irq_count + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sub_ck = 1'b1;
      @(negedge clk);
      sub_ck = 1'b0;
    end
  endtask

  task automatic write(input logic [31:0] d);
    @(negedge clk);
    wr    = 1'b1;
    wdata = d;
    @(negedge clk);
    wr    = 1'b0;
    wdata = 32'h0;
  endtask

  // Starting with tm_sub=0: three sub-second pulses, preset the time, let the
  // pipeline settle, then the fourth pulse ticks (optionally with a
  // coincident clear-overflow write).
  task force_tick(input logic [23:0] v, input logic clrovf);
    pulse(3);
    @(negedge clk);
    force_val = v;
    force dut.bcd_time = force_val;
    repeat (3) @(negedge clk);
    release dut.bcd_time;
    sub_ck = 1'b1;
    if (clrovf) begin
      wr    = 1'b1;
      wdata = 32'h9;
    end
    @(negedge clk);
    sub_ck = 1'b0;
    wr     = 1'b0;
    wdata  = 32'h0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_data", o_data, 32'h0);
    check("reset_lap", o_lap, 32'h0);
    check("reset_irq", {31'h0, o_int}, 32'h0);
    rst = 1'b0;

    // 1: run, 40 sub-second pulses -> 10 seconds
    write(32'h1);
    check("run_start", o_data, 32'h01000000);
    pulse(40);
    check("count_10s", o_data, 32'h01000010);

    // 2: continue to 00:00:59, then carry into minutes
    pulse(196);
    check("count_59s", o_data, 32'h01000059);
    pulse(4);
    check("carry_min", o_data, 32'h01000100);
    #1;
    check("no_irq_yet", irq_count, 0);

    // Hour carries
    force_tick(24'h005959, 1'b0);
    check("carry_hour", o_data, 32'h01010000);
    force_tick(24'h095959, 1'b0);
    check("carry_hr_tens", o_data, 32'h01100000);

    // 3: wrap from 99:59:59
    force_tick(24'h995959, 1'b0);
    check("wrap_time", o_data, 32'h03000000);
    check("wrap_irq", {31'h0, o_int}, 32'h1);
    @(negedge clk);
    check("irq_one_cycle", {31'h0, o_int}, 32'h0);
    write(32'h9);
    check("clr_ovf", o_data, 32'h01000000);

    // Overflow set beats a coincident clear-overflow
    force_tick(24'h995959, 1'b1);
    check("ovf_set_wins", o_data, 32'h03000000);
    write(32'h9);
    check("clr_ovf2", o_data, 32'h01000000);

    // 4: lap at 00:00:05 with tm_sub=2
    pulse(22);
    check("pre_lap", o_data, 32'h01000005);
    write(32'h5);
    check("lap_value", o_lap, LAP_EXP);
    check("lap_keeps_time", o_data, 32'h01000005);
    pulse(2);
    check("after_lap", o_data, 32'h01000006);

    // 5: stop freezes, resume keeps tm_sub, clear beats a tick
    pulse(2);
    write(32'h0);
    check("stopped", o_data, 32'h00000006);
    pulse(10);
    check("frozen", o_data, 32'h00000006);
    write(32'h1);
    pulse(2);
    check("resume_tm_sub", o_data, 32'h01000007);
    pulse(3);
    check("pre_clear", o_data, 32'h01000007);
    @(negedge clk);
    sub_ck = 1'b1;
    wr     = 1'b1;
    wdata  = 32'h3;
    @(negedge clk);
    sub_ck = 1'b0;
    wr     = 1'b0;
    wdata  = 32'h0;
    check("clear_wins", o_data, 32'h01000000);
    check("clear_no_irq", {31'h0, o_int}, 32'h0);
    pulse(4);
    check("after_clear", o_data, 32'h01000001);

    // 6: reset mid-count
    pulse(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_data", o_data, 32'h0);
    check("mid_reset_lap", o_lap, 32'h0);
    check("mid_reset_irq", {31'h0, o_int}, 32'h0);
    rst = 1'b0;
    write(32'h1);
    pulse(3);
    check("post_reset_sub", o_data, 32'h01000000);
    pulse(1);
    check("post_reset_tick", o_data, 32'h01000001);

    #1;
    check("irq_total", irq_count, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
